// File: rtl/dm_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package : dm_arb_pkg
// Shared widths and FSM state encoding for the data-memory access arbiter.
// Rev     : 1.0
// ============================================================================
package dm_arb_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

endpackage : dm_arb_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module : rr_arb2
// Two-way round-robin pick: on a tie, the requester not granted last wins.
// Rev    : 1.0
// ============================================================================
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_grant ? 2'b01 : 2'b10;
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/dm_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module : dm_access_arbiter
// Arbitrates SPI-slave (r0) and host (r1) accesses onto one synchronous-read
// data memory, with lock bursts bounded by a starvation guard.
// Rev    : 1.0
// ============================================================================
module dm_access_arbiter
    import dm_arb_pkg::*;
#(
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic              r0_lock,
    output logic              r0_gnt,
    output logic              r0_rvalid,

    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    input  logic              r1_lock,
    output logic              r1_gnt,
    output logic              r1_rvalid,

    output logic [DATA_W-1:0] rdata,

    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_din,
    output logic              dm_we,
    input  logic [DATA_W-1:0] dm_dout
);

    localparam int                C_CNT_W     = $clog2(LOCK_MAX + 1);
    // The acquiring grant in IDLE is the first of the LOCK_MAX owner grants.
    localparam logic [C_CNT_W-1:0] C_CNT_LIMIT = C_CNT_W'(LOCK_MAX - 1);

    arb_state_t         r_state;
    logic               r_last_grant;
    logic [C_CNT_W-1:0] r_cnt;
    logic               r_rvalid0;
    logic               r_rvalid1;

    logic [1:0]         w_rr_gnt;
    logic [1:0]         w_gnt;
    logic [C_CNT_W-1:0] w_cnt_inc;
    logic               w_cnt_hit;

    rr_arb2 u_rr_arb2 (
        .req        ({r1_req, r0_req}),
        .last_grant (r_last_grant),
        .gnt        (w_rr_gnt)
    );

    always_comb begin
        w_gnt = 2'b00;
        case (r_state)
            IDLE: w_gnt = w_rr_gnt;
            OWN0: begin
                if (r0_req)      w_gnt = 2'b01;
                else if (r1_req) w_gnt = 2'b10;
            end
            OWN1: begin
                if (r1_req)      w_gnt = 2'b10;
                else if (r0_req) w_gnt = 2'b01;
            end
            default: w_gnt = 2'b00;
        endcase
        // Keep the memory port quiet while reset is held, even with live requests.
        if (!reset_n) begin
            w_gnt = 2'b00;
        end
    end

    assign w_cnt_inc = r_cnt + C_CNT_W'(1);
    assign w_cnt_hit = (w_cnt_inc == C_CNT_LIMIT);

    always_comb begin
        dm_addr = '0;
        dm_din  = '0;
        dm_we   = 1'b0;
        if (w_gnt[0]) begin
            dm_addr = r0_addr;
            dm_din  = r0_wdata;
            dm_we   = r0_we;
        end else if (w_gnt[1]) begin
            dm_addr = r1_addr;
            dm_din  = r1_wdata;
            dm_we   = r1_we;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
            r_rvalid0    <= 1'b0;
            r_rvalid1    <= 1'b0;
        end else begin
            r_rvalid0 <= w_gnt[0] & ~r0_we;
            r_rvalid1 <= w_gnt[1] & ~r1_we;
            if (|w_gnt) begin
                r_last_grant <= w_gnt[1];
            end
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_gnt[0] && r0_lock)      r_state <= OWN0;
                    else if (w_gnt[1] && r1_lock) r_state <= OWN1;
                end
                OWN0: begin
                    if (!r0_lock) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (!r1_req) begin
                        r_cnt <= '0;
                    end else if (w_gnt[0]) begin
                        if (w_cnt_hit) begin
                            r_state <= IDLE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                end
                OWN1: begin
                    if (!r1_lock) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (!r0_req) begin
                        r_cnt <= '0;
                    end else if (w_gnt[1]) begin
                        if (w_cnt_hit) begin
                            r_state <= IDLE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign r0_gnt    = w_gnt[0];
    assign r1_gnt    = w_gnt[1];
    assign r0_rvalid = r_rvalid0;
    assign r1_rvalid = r_rvalid1;
    assign rdata     = dm_dout;

endmodule : dm_access_arbiter
`default_nettype wire

// File: tb/tb_dm_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_dm_access_arbiter
// Scoreboard bench for dm_access_arbiter with a behavioural sync-read memory.
// Rev    : 1.0
// ============================================================================
module tb_dm_access_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       r0_req, r0_we, r0_lock, r1_req, r1_we, r1_lock;
    logic [6:0] r0_addr, r1_addr;
    logic [7:0] r0_wdata, r1_wdata;
    logic       r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
    logic [7:0] rdata;
    logic [6:0] dm_addr;
    logic [7:0] dm_din;
    logic       dm_we;
    logic [7:0] dm_dout;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct packed {
        logic [31:0] cyc;
        logic        both;
        logic        who;
        logic        we;
        logic [6:0]  addr;
        logic [7:0]  din;
    } gexp_t;

    typedef struct packed {
        logic [31:0] cyc;
        logic        both;
        logic        who;
        logic [7:0]  data;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];

    logic [7:0] mem [0:127];

    dm_access_arbiter #(.LOCK_MAX(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .r0_req    (r0_req),
        .r0_we     (r0_we),
        .r0_addr   (r0_addr),
        .r0_wdata  (r0_wdata),
        .r0_lock   (r0_lock),
        .r0_gnt    (r0_gnt),
        .r0_rvalid (r0_rvalid),
        .r1_req    (r1_req),
        .r1_we     (r1_we),
        .r1_addr   (r1_addr),
        .r1_wdata  (r1_wdata),
        .r1_lock   (r1_lock),
        .r1_gnt    (r1_gnt),
        .r1_rvalid (r1_rvalid),
        .rdata     (rdata),
        .dm_addr   (dm_addr),
        .dm_din    (dm_din),
        .dm_we     (dm_we),
        .dm_dout   (dm_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        dm_dout = 8'h00;
    end

    always @(posedge clk) begin
        if (dm_we) mem[dm_addr] <= dm_din;
        dm_dout <= mem[dm_addr];
    end

    // Monitor: compares every presented grant / read result against the queues.
    always @(negedge clk) begin
        gexp_t ge, ga;
        rexp_t re, ra;
        if (!reset_n) begin
            checks++;
            if ({r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, dm_we, dm_addr, dm_din} !== '0) begin
                failures++;
                $display("FAIL reset_outputs cyc=%0d got gnt=%b%b rv=%b%b we=%b addr=%h din=%h required all zero",
                         cyc, r1_gnt, r0_gnt, r1_rvalid, r0_rvalid, dm_we, dm_addr, dm_din);
            end
        end else begin
            if (r0_gnt || r1_gnt) begin
                checks++;
                ga = '{cyc: cyc, both: r0_gnt & r1_gnt, who: r1_gnt, we: dm_we, addr: dm_addr, din: dm_din};
                if (gq.size() == 0) begin
                    failures++;
                    $display("FAIL grant_unexpected got=%p", ga);
                end else begin
                    ge = gq.pop_front();
                    if (ga !== ge) begin
                        failures++;
                        $display("FAIL grant got=%p required=%p", ga, ge);
                    end
                end
            end else begin
                checks++;
                if (dm_we !== 1'b0) begin
                    failures++;
                    $display("FAIL idle_we cyc=%0d got dm_we=%b required 0", cyc, dm_we);
                end
            end
            if (r0_rvalid || r1_rvalid) begin
                checks++;
                ra = '{cyc: cyc, both: r0_rvalid & r1_rvalid, who: r1_rvalid, data: rdata};
                if (rq.size() == 0) begin
                    failures++;
                    $display("FAIL rvalid_unexpected got=%p", ra);
                end else begin
                    re = rq.pop_front();
                    if (ra !== re) begin
                        failures++;
                        $display("FAIL rvalid got=%p required=%p", ra, re);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_r0(input logic req, input logic we, input logic [6:0] addr,
                          input logic [7:0] wdata, input logic lock);
        r0_req = req; r0_we = we; r0_addr = addr; r0_wdata = wdata; r0_lock = lock;
    endtask

    task automatic set_r1(input logic req, input logic we, input logic [6:0] addr,
                          input logic [7:0] wdata, input logic lock);
        r1_req = req; r1_we = we; r1_addr = addr; r1_wdata = wdata; r1_lock = lock;
    endtask

    task automatic exp_g(input logic who, input logic we, input logic [6:0] addr, input logic [7:0] din);
        gq.push_back('{cyc: cyc, both: 1'b0, who: who, we: we, addr: addr, din: din});
    endtask

    task automatic exp_r(input logic who, input logic [7:0] data);
        rq.push_back('{cyc: cyc + 1, both: 1'b0, who: who, data: data});
    endtask

    task automatic idle_all();
        set_r0(1'b0, 1'b0, 7'h00, 8'h00, 1'b0);
        set_r1(1'b0, 1'b0, 7'h00, 8'h00, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        idle_all();
        repeat (3) step();
        reset_n = 1'b1;

        // Single write from r0, then r1 reads it back.
        set_r0(1'b1, 1'b1, 7'h05, 8'hA5, 1'b0);
        exp_g(1'b0, 1'b1, 7'h05, 8'hA5);
        step();
        idle_all();
        set_r1(1'b1, 1'b0, 7'h05, 8'h00, 1'b0);
        exp_g(1'b1, 1'b0, 7'h05, 8'h00);
        exp_r(1'b1, 8'hA5);
        step();
        idle_all();
        step();

        // Fresh reset, then both requesting without lock: strict alternation from r0.
        reset_n = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
        set_r0(1'b1, 1'b1, 7'h20, 8'h11, 1'b0);
        set_r1(1'b1, 1'b0, 7'h05, 8'h00, 1'b0);
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) exp_g(1'b0, 1'b1, 7'h20, 8'h11);
            else begin
                exp_g(1'b1, 1'b0, 7'h05, 8'h00);
                exp_r(1'b1, 8'hA5);
            end
            step();
        end

        // Locked 4-byte burst by r0 while r1 waits.
        set_r1(1'b1, 1'b0, 7'h20, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            set_r0(1'b1, 1'b1, 7'h10 + 7'(i), 8'hB0 + 8'(i), 1'b1);
            exp_g(1'b0, 1'b1, 7'h10 + 7'(i), 8'hB0 + 8'(i));
            step();
        end
        set_r0(1'b0, 1'b0, 7'h00, 8'h00, 1'b0);
        exp_g(1'b1, 1'b0, 7'h20, 8'h00);
        exp_r(1'b1, 8'h11);
        step();
        set_r1(1'b1, 1'b0, 7'h13, 8'h00, 1'b0);
        exp_g(1'b1, 1'b0, 7'h13, 8'h00);
        exp_r(1'b1, 8'hB3);
        step();
        idle_all();
        step();

        // r0 holds lock indefinitely: exactly 16 grants before r1 is served.
        set_r0(1'b1, 1'b1, 7'h30, 8'h5A, 1'b1);
        set_r1(1'b1, 1'b0, 7'h10, 8'h00, 1'b0);
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_g(1'b0, 1'b1, 7'h30, 8'h5A);
            else begin
                exp_g(1'b1, 1'b0, 7'h10, 8'h00);
                exp_r(1'b1, 8'hB0);
            end
            step();
        end
        idle_all();
        step();
        step();

        // Reset right after an r1 read grant: its read result must never appear.
        set_r1(1'b1, 1'b0, 7'h05, 8'h00, 1'b0);
        exp_g(1'b1, 1'b0, 7'h05, 8'h00);
        step();
        reset_n = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
        set_r1(1'b0, 1'b0, 7'h00, 8'h00, 1'b0);
        set_r0(1'b1, 1'b0, 7'h12, 8'h00, 1'b0);
        exp_g(1'b0, 1'b0, 7'h12, 8'h00);
        exp_r(1'b0, 8'hB2);
        step();
        idle_all();
        repeat (3) step();

        checks++;
        if (gq.size() != 0) begin
            failures++;
            $display("FAIL grant_queue_drain got=%0d pending required 0", gq.size());
        end
        checks++;
        if (rq.size() != 0) begin
            failures++;
            $display("FAIL rvalid_queue_drain got=%0d pending required 0", rq.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_dm_access_arbiter
`default_nettype wire
